// File: rtl/decimal_entry.sv
// Keypad-style decimal entry: debounced pushbuttons accumulate BCD digits into a
// 32-bit binary word that is offered to a consumer over a valid/ready handshake.
module decimal_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS      = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_sw,
  input  logic        key_digit,
  input  logic        key_commit,
  input  logic        key_clear,
  input  logic        data_ready,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [31:0] acc_value,
  output logic [3:0]  digit_count,
  output logic        error,
  output logic [1:0]  state_dbg
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t state;

  // Key lanes: bit 0 digit, bit 1 commit, bit 2 clear. All active-low raw inputs.
  logic [2:0]    keys;
  logic [2:0]    sync1, sync2, deb, deb_d, press;
  logic [CW-1:0] cnt [3];

  assign keys = {key_clear, key_commit, key_digit};

  // Released (1) is the reset level, so a key held through reset is a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
      deb_d <= deb;
      press <= deb_d & ~deb;
    end
  end

  // Clear beats commit beats digit; losers in the same cycle are dropped.
  logic clr, com, dig;
  assign clr = press[2];
  assign com = press[1] & ~press[2];
  assign dig = press[0] & ~press[1] & ~press[2];

  logic [35:0] next_val;
  logic        digit_ok, overflow, full;

  assign next_val = ({4'b0, acc_value} << 3) + ({4'b0, acc_value} << 1) + {32'b0, digit_sw};
  assign digit_ok = (digit_sw <= 4'd9);
  assign overflow = (next_val > 36'h0_FFFF_FFFF);
  assign full     = (digit_count == 4'(MAX_DIGITS));

  // Handshake: data_out is loaded on the same edge data_valid rises and is frozen
  // while data_valid is high; the transfer happens on any edge where data_valid
  // and data_ready are both high, after which data_valid is low for >= 1 cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      data_out    <= '0;
      data_valid  <= 1'b0;
      acc_value   <= '0;
      digit_count <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (com) begin
            data_out   <= '0;
            data_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (dig) begin
            if (digit_ok) begin
              acc_value   <= {28'b0, digit_sw};
              digit_count <= 4'd1;
              state       <= S_ENTRY;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_ENTRY: begin
          if (clr) begin
            acc_value   <= '0;
            digit_count <= '0;
            state       <= S_IDLE;
          end else if (com) begin
            data_out   <= acc_value;
            data_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (dig) begin
            if (!digit_ok || overflow || full) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              acc_value   <= next_val[31:0];
              digit_count <= digit_count + 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (data_ready) begin
            data_valid  <= 1'b0;
            acc_value   <= '0;
            digit_count <= '0;
            state       <= S_IDLE;
          end
        end
        S_ERR: begin
          if (clr) begin
            error       <= 1'b0;
            acc_value   <= '0;
            digit_count <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry with a short debounce window.
module tb_decimal_entry;

  localparam int DEB = 4;
  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_ENTRY = 32'd1;
  localparam logic [31:0] ST_HOLD  = 32'd2;
  localparam logic [31:0] ST_ERR   = 32'd3;

  logic        clock;
  logic        reset;
  logic [3:0]  digit_sw;
  logic        key_digit, key_commit, key_clear;
  logic        data_ready;
  logic [31:0] data_out;
  logic        data_valid;
  logic [31:0] acc_value;
  logic [3:0]  digit_count;
  logic        error;
  logic [1:0]  state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  decimal_entry #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .digit_sw    (digit_sw),
    .key_digit   (key_digit),
    .key_commit  (key_commit),
    .key_clear   (key_clear),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .acc_value   (acc_value),
    .digit_count (digit_count),
    .error       (error),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // mask bits: 0 digit, 1 commit, 2 clear
  task automatic press(input logic [2:0] mask, input logic [3:0] d);
    digit_sw   = d;
    key_digit  = ~mask[0];
    key_commit = ~mask[1];
    key_clear  = ~mask[2];
    tick(10);
    key_digit  = 1'b1;
    key_commit = 1'b1;
    key_clear  = 1'b1;
    tick(10);
  endtask

  task automatic enter_digit(input logic [3:0] d);
    press(3'b001, d);
  endtask

  // Holds commit low until data_valid rises (bounded); leaves the key held.
  task automatic commit_until_valid(output int edges);
    key_commit = 1'b0;
    edges = 0;
    while (data_valid !== 1'b1 && edges < 20) begin
      tick(1);
      edges++;
    end
  endtask

  logic [3:0] digs [10];
  int n;

  initial begin
    reset      = 1'b0;
    digit_sw   = 4'd0;
    key_digit  = 1'b1;
    key_commit = 1'b1;
    key_clear  = 1'b1;
    data_ready = 1'b0;
    #12;
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_acc", acc_value, 32'd0);
    chk("reset_count", 32'(digit_count), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_state", 32'(state_dbg), ST_IDLE);
    @(negedge clock);
    reset = 1'b1;
    tick(2);

    // 1, 2, 3 then commit with ready already high
    data_ready = 1'b1;
    enter_digit(4'd1);
    chk("e1_count", 32'(digit_count), 32'd1);
    chk("e1_acc", acc_value, 32'd1);
    enter_digit(4'd2);
    chk("e2_count", 32'(digit_count), 32'd2);
    chk("e2_acc", acc_value, 32'd12);
    enter_digit(4'd3);
    chk("e3_count", 32'(digit_count), 32'd3);
    chk("e3_acc", acc_value, 32'd123);
    chk("e3_state", 32'(state_dbg), ST_ENTRY);
    commit_until_valid(n);
    chk("c123_valid", 32'(data_valid), 32'd1);
    chk("c123_data", data_out, 32'd123);
    chk("c123_latency", 32'(n), 32'(DEB + 4));
    tick(1);
    chk("c123_valid_drop", 32'(data_valid), 32'd0);
    chk("c123_acc_clr", acc_value, 32'd0);
    chk("c123_count_clr", 32'(digit_count), 32'd0);
    chk("c123_state", 32'(state_dbg), ST_IDLE);
    tick(1);
    key_commit = 1'b1;
    tick(10);
    chk("c123_single_offer", 32'(data_valid), 32'd0);

    // glitch shorter than the window, then a real press with latency measurement
    digit_sw  = 4'd7;
    key_digit = 1'b0;
    tick(3);
    key_digit = 1'b1;
    tick(10);
    chk("glitch_acc", acc_value, 32'd0);
    chk("glitch_count", 32'(digit_count), 32'd0);
    key_digit = 1'b0;
    n = 0;
    while (digit_count !== 4'd1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("press_latency", 32'(n), 32'(DEB + 4));
    tick(2);
    key_digit = 1'b1;
    tick(10);
    chk("press7_acc", acc_value, 32'd7);
    chk("press7_once", 32'(digit_count), 32'd1);
    press(3'b100, 4'd0);
    chk("clr7_acc", acc_value, 32'd0);
    chk("clr7_state", 32'(state_dbg), ST_IDLE);

    // largest representable value
    digs = '{4'd4, 4'd2, 4'd9, 4'd4, 4'd9, 4'd6, 4'd7, 4'd2, 4'd9, 4'd5};
    for (int i = 0; i < 10; i++) enter_digit(digs[i]);
    chk("max_acc", acc_value, 32'hFFFF_FFFF);
    chk("max_count", 32'(digit_count), 32'd10);
    commit_until_valid(n);
    chk("max_valid", 32'(data_valid), 32'd1);
    chk("max_data", data_out, 32'hFFFF_FFFF);
    tick(1);
    chk("max_valid_drop", 32'(data_valid), 32'd0);
    key_commit = 1'b1;
    tick(10);

    // one past the maximum overflows on the last digit
    for (int i = 0; i < 9; i++) enter_digit(digs[i]);
    chk("ovf9_acc", acc_value, 32'd429496729);
    enter_digit(4'd6);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_acc_kept", acc_value, 32'd429496729);
    chk("ovf_count_kept", 32'(digit_count), 32'd9);
    chk("ovf_state", 32'(state_dbg), ST_ERR);
    press(3'b100, 4'd0);
    chk("ovf_clr_error", 32'(error), 32'd0);
    chk("ovf_clr_acc", acc_value, 32'd0);
    chk("ovf_clr_count", 32'(digit_count), 32'd0);
    chk("ovf_clr_state", 32'(state_dbg), ST_IDLE);

    // digit-count limit with a value that never overflows
    for (int i = 0; i < 10; i++) enter_digit(4'd0);
    chk("zeros_count", 32'(digit_count), 32'd10);
    chk("zeros_state", 32'(state_dbg), ST_ENTRY);
    enter_digit(4'd0);
    chk("zeros_limit_error", 32'(error), 32'd1);
    chk("zeros_limit_count", 32'(digit_count), 32'd10);
    press(3'b100, 4'd0);
    chk("zeros_clr_error", 32'(error), 32'd0);

    // non-BCD digit from IDLE; commit ignored in ERR
    enter_digit(4'hA);
    chk("bad_digit_error", 32'(error), 32'd1);
    chk("bad_digit_state", 32'(state_dbg), ST_ERR);
    press(3'b010, 4'd0);
    chk("err_commit_valid", 32'(data_valid), 32'd0);
    chk("err_commit_state", 32'(state_dbg), ST_ERR);
    press(3'b100, 4'd0);
    chk("err_clr_error", 32'(error), 32'd0);
    chk("err_clr_state", 32'(state_dbg), ST_IDLE);

    // backpressure: commit 55 with ready low, key presses during HOLD ignored
    data_ready = 1'b0;
    enter_digit(4'd5);
    enter_digit(4'd5);
    chk("e55_acc", acc_value, 32'd55);
    commit_until_valid(n);
    chk("h55_valid", 32'(data_valid), 32'd1);
    chk("h55_data", data_out, 32'd55);
    tick(2);
    key_commit = 1'b1;
    tick(10);
    enter_digit(4'd3);
    press(3'b100, 4'd0);
    chk("h55_valid_held", 32'(data_valid), 32'd1);
    chk("h55_data_held", data_out, 32'd55);
    chk("h55_acc_held", acc_value, 32'd55);
    chk("h55_count_held", 32'(digit_count), 32'd2);
    chk("h55_state", 32'(state_dbg), ST_HOLD);
    data_ready = 1'b1;
    tick(1);
    chk("h55_xfer_valid", 32'(data_valid), 32'd0);
    chk("h55_xfer_acc", acc_value, 32'd0);
    chk("h55_xfer_state", 32'(state_dbg), ST_IDLE);

    // digit and clear in the same cycle: clear wins
    enter_digit(4'd8);
    chk("e8_acc", acc_value, 32'd8);
    press(3'b101, 4'd9);
    chk("tie_acc", acc_value, 32'd0);
    chk("tie_count", 32'(digit_count), 32'd0);
    chk("tie_state", 32'(state_dbg), ST_IDLE);

    // reset while holding an offer; held commit key re-fires after release
    data_ready = 1'b0;
    enter_digit(4'd6);
    commit_until_valid(n);
    chk("rh_valid", 32'(data_valid), 32'd1);
    chk("rh_data", data_out, 32'd6);
    reset = 1'b0;
    #2;
    chk("rh_async_data", data_out, 32'd0);
    chk("rh_async_valid", 32'(data_valid), 32'd0);
    chk("rh_async_acc", acc_value, 32'd0);
    chk("rh_async_count", 32'(digit_count), 32'd0);
    chk("rh_async_error", 32'(error), 32'd0);
    chk("rh_async_state", 32'(state_dbg), ST_IDLE);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n = 0;
    while (data_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("rh_refire_valid", 32'(data_valid), 32'd1);
    chk("rh_refire_data", data_out, 32'd0);
    data_ready = 1'b1;
    tick(1);
    chk("rh_refire_xfer", 32'(data_valid), 32'd0);
    key_commit = 1'b1;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
